// File: rtl/fclass_pipe_if.sv
// ---------------------------------------------------------------------------
// fclass_pipe_if -- operand/result bus of the pipelined FP classifier.
//
// Signals:
//   flush      synchronous pipeline kill (issuer -> unit)
//   in_valid   operand valid             (issuer -> unit)
//   in_ready   unit can accept operand   (unit -> issuer)
//   in_data    FP operand, FLEN bits     (issuer -> unit)
//   in_fmt     0 = single, 1 = double    (issuer -> unit)
//   in_tag     opaque tag                (issuer -> unit)
//   out_valid  result valid              (unit -> consumer)
//   out_ready  consumer accepts result   (consumer -> unit)
//   out_class  32-bit class mask         (unit -> consumer)
//   out_tag    tag of the result         (unit -> consumer)
//
// Modports: master = issuer/consumer side, slave = the classifier unit.
// ---------------------------------------------------------------------------
interface fclass_pipe_if #(
    parameter int FLEN  = 64,
    parameter int TAG_W = 5
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [FLEN-1:0]  in_data;
    logic             in_fmt;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_class;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output flush, in_valid, in_data, in_fmt, in_tag, out_ready,
        input  in_ready, out_valid, out_class, out_tag
    );

    modport slave (
        input  flush, in_valid, in_data, in_fmt, in_tag, out_ready,
        output in_ready, out_valid, out_class, out_tag
    );
endinterface

// File: rtl/fclass_pipe.sv
// ---------------------------------------------------------------------------
// fclass_pipe -- two-stage pipelined RISC-V FCLASS.S / FCLASS.D unit.
//
// S1 registers the decoded field flags (sign, exponent all-ones/all-zeros,
// mantissa zero, mantissa MSB, NaN-box ok) plus the tag. S2 registers the
// one-hot class mask plus the tag and drives the result side of the bus.
// Capacity is two operands; order is preserved; flush kills both stages.
//
// Ports:
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    fclass_pipe_if.slave (flush, in_* handshake, out_* handshake)
// ---------------------------------------------------------------------------
module fclass_pipe #(
    parameter int FLEN  = 64,
    parameter int TAG_W = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    fclass_pipe_if.slave  bus
);

    // Class mask bit positions (architectural order).
    localparam int NEG_INF  = 0;
    localparam int NEG_NORM = 1;
    localparam int NEG_SUB  = 2;
    localparam int NEG_ZERO = 3;
    localparam int POS_ZERO = 4;
    localparam int POS_SUB  = 5;
    localparam int POS_NORM = 6;
    localparam int POS_INF  = 7;
    localparam int SNAN     = 8;
    localparam int QNAN     = 9;

    // ---------------------------------------------------------------
    // Operand decode (combinational, feeds S1 only)
    // ---------------------------------------------------------------
    logic d_sign;
    logic d_exp_ones;
    logic d_exp_zero;
    logic d_man_zero;
    logic d_man_msb;
    logic d_box_ok;

    generate
        if (FLEN == 64) begin : g_flen64
            always_comb begin
                // NOTE: every output of a combinational block gets a default
                // first, so no path through the branches can infer a latch.
                d_sign     = 1'b0;
                d_exp_ones = 1'b0;
                d_exp_zero = 1'b0;
                d_man_zero = 1'b0;
                d_man_msb  = 1'b0;
                d_box_ok   = 1'b1;
                if (bus.in_fmt) begin
                    d_sign     = bus.in_data[63];
                    d_exp_ones = &bus.in_data[62:52];
                    d_exp_zero = ~|bus.in_data[62:52];
                    d_man_zero = ~|bus.in_data[51:0];
                    d_man_msb  = bus.in_data[51];
                end else begin
                    // A single held in a 64-bit register must be NaN-boxed.
                    d_box_ok   = &bus.in_data[63:32];
                    d_sign     = bus.in_data[31];
                    d_exp_ones = &bus.in_data[30:23];
                    d_exp_zero = ~|bus.in_data[30:23];
                    d_man_zero = ~|bus.in_data[22:0];
                    d_man_msb  = bus.in_data[22];
                end
            end
        end else begin : g_flen32
            // Only single precision exists; in_fmt is ignored.
            always_comb begin
                d_box_ok   = 1'b1;
                d_sign     = bus.in_data[31];
                d_exp_ones = &bus.in_data[30:23];
                d_exp_zero = ~|bus.in_data[30:23];
                d_man_zero = ~|bus.in_data[22:0];
                d_man_msb  = bus.in_data[22];
            end
        end
    endgenerate

    // ---------------------------------------------------------------
    // Pipeline state
    // ---------------------------------------------------------------
    logic             s1_valid;
    logic             s1_sign;
    logic             s1_exp_ones;
    logic             s1_exp_zero;
    logic             s1_man_zero;
    logic             s1_man_msb;
    logic             s1_box_ok;
    logic [TAG_W-1:0] s1_tag;

    logic             s2_valid;
    logic [9:0]       s2_mask;
    logic [TAG_W-1:0] s2_tag;

    // ---------------------------------------------------------------
    // Flow control
    // ---------------------------------------------------------------
    logic s2_drain;
    logic s2_free;
    logic advance;
    logic accept;

    assign s2_drain     = s2_valid & bus.out_ready;
    assign s2_free      = ~s2_valid | bus.out_ready;
    assign advance      = s1_valid & s2_free;
    // S1 can take a new operand if it is empty or moving on this edge.
    assign bus.in_ready = ~s1_valid | s2_free;
    assign accept       = bus.in_valid & bus.in_ready;

    // ---------------------------------------------------------------
    // Class mask from S1 flags
    // ---------------------------------------------------------------
    logic [9:0] s1_mask;

    always_comb begin
        s1_mask = '0;
        if (!s1_box_ok) begin
            // Improperly boxed single reads as the canonical quiet NaN.
            s1_mask[QNAN] = 1'b1;
        end else if (s1_exp_ones) begin
            if (s1_man_zero)     s1_mask[s1_sign ? NEG_INF : POS_INF] = 1'b1;
            else if (s1_man_msb) s1_mask[QNAN] = 1'b1;
            else                 s1_mask[SNAN] = 1'b1;
        end else if (s1_exp_zero) begin
            if (s1_man_zero) s1_mask[s1_sign ? NEG_ZERO : POS_ZERO] = 1'b1;
            else             s1_mask[s1_sign ? NEG_SUB  : POS_SUB]  = 1'b1;
        end else begin
            s1_mask[s1_sign ? NEG_NORM : POS_NORM] = 1'b1;
        end
    end

    // ---------------------------------------------------------------
    // S1 register
    // ---------------------------------------------------------------
    // NOTE: sequential state is written only with non-blocking assignments,
    // so every register samples values from before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid    <= 1'b0;
            s1_sign     <= 1'b0;
            s1_exp_ones <= 1'b0;
            s1_exp_zero <= 1'b0;
            s1_man_zero <= 1'b0;
            s1_man_msb  <= 1'b0;
            s1_box_ok   <= 1'b1;
            s1_tag      <= '0;
        end else if (bus.flush) begin
            s1_valid <= 1'b0;
        end else if (accept) begin
            s1_valid    <= 1'b1;
            s1_sign     <= d_sign;
            s1_exp_ones <= d_exp_ones;
            s1_exp_zero <= d_exp_zero;
            s1_man_zero <= d_man_zero;
            s1_man_msb  <= d_man_msb;
            s1_box_ok   <= d_box_ok;
            s1_tag      <= bus.in_tag;
        end else if (advance) begin
            s1_valid <= 1'b0;
        end
    end

    // ---------------------------------------------------------------
    // S2 register (drives the result side)
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_mask  <= '0;
            s2_tag   <= '0;
        end else if (bus.flush) begin
            s2_valid <= 1'b0;
        end else if (advance) begin
            s2_valid <= 1'b1;
            s2_mask  <= s1_mask;
            s2_tag   <= s1_tag;
        end else if (s2_drain) begin
            s2_valid <= 1'b0;
        end
    end

    assign bus.out_valid = s2_valid;
    assign bus.out_class = {22'b0, s2_mask};
    assign bus.out_tag   = s2_tag;

endmodule

// File: tb/tb_fclass_pipe.sv
// ---------------------------------------------------------------------------
// tb_fclass_pipe -- self-checking bench for fclass_pipe (FLEN=64, TAG_W=5).
// Expected results are pushed to a queue when an operand is accepted and
// popped when the unit hands out a result.
// ---------------------------------------------------------------------------
module tb_fclass_pipe;

    localparam int FLEN      = 64;
    localparam int TAG_W     = 5;
    localparam int STALL_MAX = 100;

    typedef struct packed {
        logic [9:0]       cls;
        logic [TAG_W-1:0] tag;
    } exp_t;

    logic clk;
    logic rst_n;
    exp_t sb[$];
    int   n_checks;
    int   n_fail;
    bit   rand_bp;

    fclass_pipe_if #(.FLEN(FLEN), .TAG_W(TAG_W)) bus ();

    fclass_pipe #(.FLEN(FLEN), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference classifier, written from the architectural definition.
    function automatic logic [9:0] ref_class(input logic [63:0] d, input logic fmt);
        logic        s;
        logic        e_max;
        logic        e_min;
        logic [51:0] m;
        if (!fmt) begin
            if (d[63:32] != 32'hFFFF_FFFF) return 10'h200;
            s     = d[31];
            e_max = (d[30:23] == 8'hFF);
            e_min = (d[30:23] == 8'h00);
            m     = {d[22:0], 29'b0};
        end else begin
            s     = d[63];
            e_max = (d[62:52] == 11'h7FF);
            e_min = (d[62:52] == 11'h000);
            m     = d[51:0];
        end
        if (e_max) begin
            if (m == '0)  return s ? 10'h001 : 10'h080;
            if (m[51])    return 10'h200;
            return 10'h100;
        end
        if (e_min) begin
            if (m == '0)  return s ? 10'h008 : 10'h010;
            return s ? 10'h004 : 10'h020;
        end
        return s ? 10'h002 : 10'h040;
    endfunction

    // Result monitor: sampled mid-cycle; a transfer happens on the next edge.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 64'(sb.size()), 64'd1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_class", 64'(bus.out_class), {54'b0, e.cls});
                check("out_tag", 64'(bus.out_tag), 64'(e.tag));
            end
        end
    end

    // Present one operand and hold it until accepted; the expectation is
    // queued in the cycle whose closing edge performs the transfer.
    task automatic send(input logic [63:0] d, input logic f, input logic [TAG_W-1:0] t);
        int  n;
        bit  done;
        @(posedge clk); #1;
        if (rand_bp) bus.out_ready = 1'($urandom_range(0, 1));
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_fmt   = f;
        bus.in_tag   = t;
        n    = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (bus.in_ready) begin
                sb.push_back('{cls: ref_class(d, f), tag: t});
                done = 1'b1;
            end else begin
                n++;
                if (n >= STALL_MAX) begin
                    check("send_timeout", 64'(n), 64'd0);
                    done = 1'b1;
                end else begin
                    @(posedge clk); #1;
                    if (rand_bp) bus.out_ready = 1'($urandom_range(0, 1));
                end
            end
        end
    endtask

    task automatic idle();
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < STALL_MAX) begin
            @(negedge clk);
            n++;
        end
        check("drain", 64'(sb.size()), 64'd0);
    endtask

    function automatic logic [63:0] rand_operand(input logic fmt);
        logic [63:0] d;
        d = {$urandom, $urandom};
        case ($urandom_range(0, 3))
            0: if (fmt) d[62:52] = '1; else d[30:23] = '1;
            1: if (fmt) d[62:52] = '0; else d[30:23] = '0;
            2: if (fmt) d[51:0]  = '0; else d[22:0]  = '0;
            default: ;
        endcase
        if (!fmt && $urandom_range(0, 7) != 0) d[63:32] = 32'hFFFF_FFFF;
        return d;
    endfunction

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rand_bp       = 1'b0;
        rst_n         = 1'b0;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_fmt    = 1'b0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;

        // Reset state
        #12;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_class", 64'(bus.out_class), 64'd0);
        check("rst_out_tag", 64'(bus.out_tag), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);

        // Basic boxed single with exact two-cycle latency
        send(64'hFFFF_FFFF_3F80_0000, 1'b0, 5'd3);
        check("lat_c0", 64'(bus.out_valid), 64'd0);
        idle();
        @(negedge clk);
        check("lat_c1", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        check("lat_c2_valid", 64'(bus.out_valid), 64'd1);
        check("lat_c2_class", 64'(bus.out_class), 64'h040);
        check("lat_c2_tag", 64'(bus.out_tag), 64'd3);
        wait_drain();

        // Unboxed single and single specials
        send(64'h0000_0000_3F80_0000, 1'b0, 5'd4);
        send(64'hFFFF_FFFF_FF80_0000, 1'b0, 5'd5);
        send(64'hFFFF_FFFF_7FA0_0000, 1'b0, 5'd6);
        send(64'hFFFF_FFFF_8000_0000, 1'b0, 5'd7);
        idle();
        wait_drain();

        // Double sweep, back to back
        send(64'h7FF0_0000_0000_0001, 1'b1, 5'd10);
        send(64'h7FF8_0000_0000_0000, 1'b1, 5'd11);
        send(64'hFFF0_0000_0000_0000, 1'b1, 5'd12);
        send(64'h8000_0000_0000_0001, 1'b1, 5'd13);
        send(64'h0000_0000_0000_0000, 1'b1, 5'd14);
        send(64'h7FF0_0000_0000_0000, 1'b1, 5'd15);
        idle();
        wait_drain();

        // Backpressure: fill both stages, third operand must wait
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        send(64'hFFFF_FFFF_3F80_0000, 1'b0, 5'd1);
        send(64'hFFF0_0000_0000_0000, 1'b1, 5'd2);
        @(posedge clk); #1;
        bus.in_data = 64'h7FF8_0000_0000_0000;
        bus.in_fmt  = 1'b1;
        bus.in_tag  = 5'd3;
        @(negedge clk);
        check("bp_in_ready", 64'(bus.in_ready), 64'd0);
        check("bp_out_valid", 64'(bus.out_valid), 64'd1);
        check("bp_tag_a", 64'(bus.out_tag), 64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_tag_hold", 64'(bus.out_tag), 64'd1);
        check("bp_class_hold", 64'(bus.out_class), 64'h040);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_in_ready_release", 64'(bus.in_ready), 64'd1);
        if (bus.in_ready) sb.push_back('{cls: 10'h200, tag: 5'd3});
        idle();
        @(negedge clk);
        check("bp_seq_t2_valid", 64'(bus.out_valid), 64'd1);
        check("bp_seq_t2", 64'(bus.out_tag), 64'd2);
        @(negedge clk);
        check("bp_seq_t3_valid", 64'(bus.out_valid), 64'd1);
        check("bp_seq_t3", 64'(bus.out_tag), 64'd3);
        wait_drain();

        // Randomised mix with random backpressure
        rand_bp = 1'b1;
        for (int i = 0; i < 60; i++) begin
            logic f;
            f = 1'($urandom_range(0, 1));
            send(rand_operand(f), f, 5'($urandom_range(0, 31)));
        end
        rand_bp = 1'b0;
        idle();
        bus.out_ready = 1'b1;
        wait_drain();

        // Flush with two in flight; the operand offered in the flush cycle dies
        bus.out_ready = 1'b0;
        send(64'hFFFF_FFFF_3F80_0000, 1'b0, 5'd20);
        send(64'h7FF0_0000_0000_0000, 1'b1, 5'd21);
        @(posedge clk); #1;
        bus.in_data = 64'h0000_0000_0000_0000;
        bus.in_fmt  = 1'b1;
        bus.in_tag  = 5'd22;
        bus.flush   = 1'b1;
        @(negedge clk);
        check("fl_pre_valid", 64'(bus.out_valid), 64'd1);
        @(posedge clk); #1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        sb.delete();
        @(negedge clk);
        check("fl_out_valid", 64'(bus.out_valid), 64'd0);
        check("fl_in_ready", 64'(bus.in_ready), 64'd1);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("fl_no_result", 64'(bus.out_valid), 64'd0);
        end

        // Asynchronous reset mid-stream
        bus.out_ready = 1'b0;
        send(64'hFFFF_FFFF_8000_0000, 1'b0, 5'd25);
        send(64'h8000_0000_0000_0001, 1'b1, 5'd26);
        idle();
        #3;
        check("ar_pre_valid", 64'(bus.out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("ar_out_valid", 64'(bus.out_valid), 64'd0);
        check("ar_out_class", 64'(bus.out_class), 64'd0);
        check("ar_out_tag", 64'(bus.out_tag), 64'd0);
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("ar_in_ready", 64'(bus.in_ready), 64'd1);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("ar_no_result", 64'(bus.out_valid), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
